control_votacion: RTL and testbench
===================================

Name: control_votacion

Overview:
- Session controller that sequences the 3-input majority voter for a three-member committee.
- Opens a voting session on `start` and captures at most one ballot per member.
- Closes the session when all three members have voted or when a timeout expires.
- Publishes the majority result, the yes-count and a one-cycle `done` pulse. Sits between the member vote buttons and the result display.

Parameters:
TIMEOUT, 100, max cycles the session stays open (>=1)
CW, 8, width of the session cycle counter (2**CW > TIMEOUT)

Ports:
clk      input   1  system clock, rising edge
reset    input   1  asynchronous reset, active-low
start    input   1  open a new session (sampled only in IDLE)
vote     input   3  vote strobe per member, bit i = member i
val      input   3  ballot value per member (1 = yes), valid with vote[i]
busy     output  1  session open (state OPEN)
voted    output  3  members whose ballot has been captured this session
done     output  1  one-cycle pulse: session closed, results valid
v        output  1  majority result (1 = two or more yes ballots)
yes      output  2  number of yes ballots (0..3)
tmo      output  1  session closed by timeout (not all members voted)

Behaviour:
- Reset (reset=0, async): state IDLE; outputs busy, voted, done, v, yes, tmo all 0; internal ballot regs and counter 0. Holds while reset=0. Reset mid-session discards all ballots; no done pulse.
- States:
  - IDLE: busy=0. start=1 -> OPEN; on that edge clear voted, ballots and counter. Results v/yes/tmo are not cleared until then.
  - OPEN: busy=1; counter increments every cycle.
  - RESULT: single cycle; done=1; unconditionally -> IDLE next edge.
- Capture (OPEN only), per member i:
  - vote[i]=1 and voted[i]=0: ballot[i]<=val[i], voted[i]<=1.
  - vote[i]=1 with voted[i]=1: ignored; the first ballot is final.
  - Any mix of members may vote in the same cycle; all are captured.
  - vote is ignored in IDLE and RESULT.
- Close condition, evaluated at each OPEN edge including ballots captured at that edge:
  - all_voted = (voted | vote) == 3'b111, or counter == TIMEOUT-1.
  - On the closing edge: state<=RESULT; done<=1 during RESULT; v, yes, tmo registered from the final ballot set.
- Result arithmetic:
  - An unvoted member counts as ballot 0 (abstention = no).
  - yes = popcount of the final ballots.
  - v = (yes >= 2), i.e. ab|ac|bc over the ballots.
  - tmo = 1 iff closed with all_voted=0. If the last vote and the timeout coincide, all_voted wins and tmo=0.
- Latency:
  - Last vote sampled at edge k -> done high from edge k until edge k+1.
  - With no votes, done rises exactly TIMEOUT cycles after the start edge.
- Holding: v, yes, tmo and voted hold after done until the next accepted start.
- start is ignored in OPEN and RESULT; a new session needs start while in IDLE.

Test Plan:
1. TIMEOUT=8; start; vote=001/val=001, then vote=010/val=010, then vote=100/val=000 on successive cycles -> done one cycle after the third strobe, v=1, yes=2, tmo=0, voted=111, busy falls with done.
2. start; vote=111, val=101 in one cycle -> done on the next cycle, v=1, yes=2, tmo=0. Repeat for all 8 val values -> v matches majority(val), yes matches popcount(val).
3. start; member 0 votes val=1, then votes again with val=0; members 1 and 2 vote 0 -> second ballot ignored, yes=1, v=0.
4. TIMEOUT=8; start; only members 0 and 1 vote, with val 0 and 1 -> done exactly 8 cycles after the start edge, v=0, yes=1, tmo=1, voted=011.
5. Drop reset to 0 mid-OPEN after one vote -> immediately busy=0, voted=000, v=0, yes=0, done=0. After reset=1, votes without start are ignored and busy stays 0.
6. start pulsed again during OPEN and during RESULT -> no restart, counter and ballots unaffected. Third vote on the timeout cycle -> tmo=0.

Source files
------------

// File: rtl/control_votacion_if.sv
// Bundles the committee-side strobes and the result-display outputs of the
// voting session controller into one port.
interface control_votacion_if;
  logic       start;
  logic [2:0] vote;
  logic [2:0] val;
  logic       busy;
  logic [2:0] voted;
  logic       done;
  logic       v;
  logic [1:0] yes;
  logic       tmo;

  modport master (
    output start, vote, val,
    input  busy, voted, done, v, yes, tmo
  );

  modport slave (
    input  start, vote, val,
    output busy, voted, done, v, yes, tmo
  );
endinterface

// File: rtl/control_votacion.sv
// Voting session controller for a three-member committee: opens on start,
// captures one ballot per member, closes on full vote or timeout, publishes majority.
module control_votacion #(
  parameter int TIMEOUT = 100,
  parameter int CW      = 8
) (
  input  logic                clk,
  input  logic                reset,
  control_votacion_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OPEN   = 2'd1,
    ST_RESULT = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [2:0]      voted_q, voted_d;
  logic [2:0]      ballot_q, ballot_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            v_q, v_d;
  logic [1:0]      yes_q, yes_d;
  logic            tmo_q, tmo_d;

  logic [2:0]      capture;
  logic [2:0]      voted_fin;
  logic [2:0]      ballot_fin;
  logic            all_voted;
  logic [1:0]      yes_fin;
  logic            v_fin;

  // A member's ballot is taken only on its first strobe; later strobes are ignored.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_member
      assign capture[gi]    = bus.vote[gi] & ~voted_q[gi];
      assign voted_fin[gi]  = voted_q[gi] | bus.vote[gi];
      assign ballot_fin[gi] = capture[gi] ? bus.val[gi] : ballot_q[gi];
    end
  endgenerate

  assign all_voted = (voted_fin == 3'b111);
  // Unvoted members keep a cleared ballot, so abstention counts as no.
  assign yes_fin   = {1'b0, ballot_fin[0]} + {1'b0, ballot_fin[1]} + {1'b0, ballot_fin[2]};
  assign v_fin     = (ballot_fin[0] & ballot_fin[1]) |
                     (ballot_fin[0] & ballot_fin[2]) |
                     (ballot_fin[1] & ballot_fin[2]);

  always_comb begin
    state_d  = state_q;
    voted_d  = voted_q;
    ballot_d = ballot_q;
    cnt_d    = cnt_q;
    v_d      = v_q;
    yes_d    = yes_q;
    tmo_d    = tmo_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d  = ST_OPEN;
          voted_d  = 3'b000;
          ballot_d = 3'b000;
          cnt_d    = '0;
        end
      end
      ST_OPEN: begin
        voted_d  = voted_fin;
        ballot_d = ballot_fin;
        cnt_d    = cnt_q + CW'(1);
        // Full participation takes priority over a coincident timeout.
        if (all_voted || (cnt_q == LAST_CNT)) begin
          state_d = ST_RESULT;
          v_d     = v_fin;
          yes_d   = yes_fin;
          tmo_d   = ~all_voted;
        end
      end
      ST_RESULT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      voted_q  <= 3'b000;
      ballot_q <= 3'b000;
      cnt_q    <= '0;
      v_q      <= 1'b0;
      yes_q    <= 2'd0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      voted_q  <= voted_d;
      ballot_q <= ballot_d;
      cnt_q    <= cnt_d;
      v_q      <= v_d;
      yes_q    <= yes_d;
      tmo_q    <= tmo_d;
    end
  end

  assign bus.busy  = (state_q == ST_OPEN);
  assign bus.done  = (state_q == ST_RESULT);
  assign bus.voted = voted_q;
  assign bus.v     = v_q;
  assign bus.yes   = yes_q;
  assign bus.tmo   = tmo_q;

endmodule

// File: tb/tb_control_votacion.sv
// Self-checking bench for control_votacion: directed scenarios plus random
// traffic, compared every cycle against a session-level behavioural model.
module tb_control_votacion;

  localparam int TIMEOUT = 8;
  localparam int CW      = 4;

  logic clk;
  logic reset;

  control_votacion_if bus ();

  control_votacion #(.TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  // Behavioural model: session open/closing flags, cycles since start, ballot set.
  bit         m_open;
  bit         m_result;
  int         m_elapsed;
  logic [2:0] m_voted;
  logic [2:0] m_ballot;
  int         m_yes;
  bit         m_v;
  bit         m_tmo;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic model_reset();
    m_open = 0; m_result = 0; m_elapsed = 0;
    m_voted = 3'b000; m_ballot = 3'b000;
    m_yes = 0; m_v = 0; m_tmo = 0;
  endtask

  task automatic model_step(input bit s, input logic [2:0] vo, input logic [2:0] va);
    bit all;
    if (m_result) begin
      m_result = 0;
    end else if (m_open) begin
      for (int i = 0; i < 3; i++)
        if (vo[i] && !m_voted[i]) begin
          m_voted[i]  = 1'b1;
          m_ballot[i] = va[i];
        end
      m_elapsed++;
      all = (m_voted == 3'b111);
      if (all || m_elapsed == TIMEOUT) begin
        m_open   = 0;
        m_result = 1;
        m_yes    = $countones(m_ballot);
        m_v      = (m_yes >= 2);
        m_tmo    = !all;
      end
    end else if (s) begin
      m_open = 1; m_elapsed = 0;
      m_voted = 3'b000; m_ballot = 3'b000;
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy",  int'(bus.busy),  int'(m_open));
      chk("done",  int'(bus.done),  int'(m_result));
      chk("voted", int'(bus.voted), int'(m_voted));
      chk("v",     int'(bus.v),     int'(m_v));
      chk("yes",   int'(bus.yes),   m_yes);
      chk("tmo",   int'(bus.tmo),   int'(m_tmo));
    end
  end

  task automatic cyc(input bit s, input logic [2:0] vo, input logic [2:0] va);
    bus.start = s; bus.vote = vo; bus.val = va;
    @(posedge clk);
    if (reset) model_step(s, vo, va);
    else       model_reset();
    #1;
    bus.start = 1'b0; bus.vote = 3'b000; bus.val = 3'b000;
  endtask

  task automatic async_reset();
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    chk("rst_busy",  int'(bus.busy),  0);
    chk("rst_voted", int'(bus.voted), 0);
    chk("rst_v",     int'(bus.v),     0);
    chk("rst_yes",   int'(bus.yes),   0);
    chk("rst_done",  int'(bus.done),  0);
    chk("rst_tmo",   int'(bus.tmo),   0);
    cyc(0, 3'b000, 3'b000);
    reset = 1'b1;
  endtask

  initial begin
    int n;
    logic [2:0] va;
    bus.start = 0; bus.vote = 0; bus.val = 0;
    reset = 1'b0;
    model_reset();
    cmp_en = 1'b1;
    #2;
    chk("init_busy", int'(bus.busy), 0);
    chk("init_done", int'(bus.done), 0);
    cyc(0, 3'b000, 3'b000);
    cyc(0, 3'b000, 3'b000);
    reset = 1'b1;
    cyc(0, 3'b000, 3'b000);

    // 1: three successive single votes
    cyc(1, 3'b000, 3'b000);
    cyc(0, 3'b001, 3'b001);
    cyc(0, 3'b010, 3'b010);
    cyc(0, 3'b100, 3'b000);
    chk("t1_done",  int'(bus.done),  1);
    chk("t1_v",     int'(bus.v),     1);
    chk("t1_yes",   int'(bus.yes),   2);
    chk("t1_tmo",   int'(bus.tmo),   0);
    chk("t1_voted", int'(bus.voted), 7);
    chk("t1_busy",  int'(bus.busy),  0);
    cyc(0, 3'b000, 3'b000);
    chk("t1_done_pulse", int'(bus.done), 0);

    // 2: simultaneous full vote over every ballot pattern
    for (int k = 0; k < 8; k++) begin
      va = 3'(k);
      cyc(1, 3'b000, 3'b000);
      cyc(0, 3'b111, va);
      chk("t2_done", int'(bus.done), 1);
      chk("t2_yes",  int'(bus.yes),  $countones(va));
      chk("t2_v",    int'(bus.v),    int'((va[0] & va[1]) | (va[0] & va[2]) | (va[1] & va[2])));
      chk("t2_tmo",  int'(bus.tmo),  0);
      cyc(0, 3'b000, 3'b000);
    end

    // 3: repeated vote by member 0 is ignored
    cyc(1, 3'b000, 3'b000);
    cyc(0, 3'b001, 3'b001);
    cyc(0, 3'b001, 3'b000);
    cyc(0, 3'b110, 3'b000);
    chk("t3_done", int'(bus.done), 1);
    chk("t3_yes",  int'(bus.yes),  1);
    chk("t3_v",    int'(bus.v),    0);
    cyc(0, 3'b000, 3'b000);

    // 4: timeout with two voters
    cyc(1, 3'b000, 3'b000);
    n = 0;
    do begin
      if (n == 0) cyc(0, 3'b011, 3'b010);
      else        cyc(0, 3'b000, 3'b000);
      n++;
    end while (!bus.done && n < 20);
    chk("t4_latency", n, TIMEOUT);
    chk("t4_v",     int'(bus.v),     0);
    chk("t4_yes",   int'(bus.yes),   1);
    chk("t4_tmo",   int'(bus.tmo),   1);
    chk("t4_voted", int'(bus.voted), 3);
    cyc(0, 3'b000, 3'b000);

    // 5: reset mid-session, then votes without start are ignored
    cyc(1, 3'b000, 3'b000);
    cyc(0, 3'b001, 3'b001);
    async_reset();
    cyc(0, 3'b111, 3'b111);
    cyc(0, 3'b111, 3'b111);
    chk("t5_busy",  int'(bus.busy),  0);
    chk("t5_voted", int'(bus.voted), 0);

    // 6: start ignored while open/result; last vote on the timeout cycle
    cyc(1, 3'b000, 3'b000);
    cyc(0, 3'b011, 3'b011);
    cyc(1, 3'b000, 3'b000);
    for (int k = 0; k < TIMEOUT - 3; k++) cyc(0, 3'b000, 3'b000);
    chk("t6_open", int'(bus.busy), 1);
    cyc(0, 3'b100, 3'b100);
    chk("t6_done", int'(bus.done), 1);
    chk("t6_tmo",  int'(bus.tmo),  0);
    chk("t6_yes",  int'(bus.yes),  3);
    cyc(1, 3'b000, 3'b000);
    chk("t6_norestart", int'(bus.busy), 0);
    chk("t6_hold_yes",  int'(bus.yes),  3);

    // Random traffic
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 199) == 0) begin
        async_reset();
      end else begin
        cyc($urandom_range(0, 3) == 0,
            {$urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0},
            3'($urandom_range(0, 7)));
      end
    end

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
